// File: rtl/gat_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : gat_host_loader
// Purpose  : Host-side BRAM load / feature readback controller for the GAT core.
//            Optional RUN watchdog enabled by defining GAT_LOADER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module gat_host_loader #(
    parameter int NUM_CH      = 3,
    parameter int TOP_WIDTH   = 32,
    parameter int ADDR_W      = 18,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int RD_LATENCY  = 2,
    parameter int TIMEOUT_CYC = 2**24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic [NUM_CH*ADDR_W-1:0] cfg_len,
    input  logic                     host_wr_en,
    input  logic [CH_W-1:0]          host_wr_ch,
    input  logic [ADDR_W+1:0]        host_wr_addr,
    input  logic [TOP_WIDTH-1:0]     host_wr_data,
    output logic [NUM_CH-1:0]        bram_we,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [TOP_WIDTH-1:0]     bram_din,
    output logic [NUM_CH-1:0]        load_done,
    output logic                     core_start,
    input  logic                     core_done,
    output logic                     gat_ready,
    input  logic                     host_rd_en,
    input  logic [ADDR_W+1:0]        host_rd_addr,
    output logic [ADDR_W-1:0]        feat_bram_addrb,
    input  logic [TOP_WIDTH-1:0]     feat_bram_dout,
    output logic [TOP_WIDTH-1:0]     host_rd_data,
    output logic                     host_rd_valid,
    output logic [TOP_WIDTH-1:0]     status
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_start_ok;
    logic                     w_expire;
    logic                     w_timeout;
    logic                     w_drop;
    logic [NUM_CH-1:0]        w_acc;
    logic [NUM_CH-1:0]        w_last;
    logic [NUM_CH-1:0]        w_len_zero;
    logic [ADDR_W:0]          w_cnt_inc [NUM_CH];
    logic [NUM_CH-1:0]        r_we;
    logic [NUM_CH-1:0]        r_load_done;
    logic [ADDR_W-1:0]        r_addr;
    logic [TOP_WIDTH-1:0]     r_din;
    logic [NUM_CH*ADDR_W-1:0] r_len;
    logic [ADDR_W:0]          r_cnt [NUM_CH];
    logic                     r_wr_err;
    logic [7:0]               r_drop_cnt;
    logic [RD_LATENCY-1:0]    r_rd_pipe;
    logic                     r_rd_valid;
    logic [TOP_WIDTH-1:0]     r_rd_data;
    logic                     w_unused;

    assign w_start_ok = cfg_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Channel match against each constant index also rejects out-of-range channels.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_acc[c]      = host_wr_en && (r_state == S_LOAD) &&
                               (host_wr_ch == CH_W'(c)) && !r_load_done[c];
        assign w_len_zero[c] = (cfg_len[c*ADDR_W +: ADDR_W] == '0);
        assign w_cnt_inc[c]  = r_cnt[c] + (ADDR_W+1)'(1);
        assign w_last[c]     = (w_cnt_inc[c] == {1'b0, r_len[c*ADDR_W +: ADDR_W]});
    end

    assign w_drop = host_wr_en && !(|w_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_load_done <= '0;
            r_len       <= '0;
            r_wr_err    <= 1'b0;
            r_drop_cnt  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            r_we <= w_acc;
            if (|w_acc) begin
                r_addr <= host_wr_addr[ADDR_W+1:2];
                r_din  <= host_wr_data;
            end
            if (w_start_ok) begin
                // Zero-length channels count as loaded from the first LOAD cycle.
                r_len       <= cfg_len;
                r_load_done <= w_len_zero;
                r_wr_err    <= 1'b0;
                r_drop_cnt  <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    r_cnt[c] <= '0;
                end
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_acc[c]) begin
                        r_cnt[c] <= w_cnt_inc[c];
                        if (w_last[c]) begin
                            r_load_done[c] <= 1'b1;
                        end
                    end
                end
                if (w_drop) begin
                    r_wr_err <= 1'b1;
                    if (r_drop_cnt != 8'hFF) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                end
            end
        end
    end

`ifdef GAT_LOADER_TIMEOUT_EN
    localparam int c_to_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [c_to_w-1:0] r_run_cnt;
    logic              r_timeout;

    // core_done in the expiry cycle takes priority over the watchdog.
    assign w_expire  = (r_state == S_RUN) && !core_done &&
                       (r_run_cnt == c_to_w'(TIMEOUT_CYC - 1));
    assign w_timeout = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + c_to_w'(1) : '0;
            if (w_start_ok) begin
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_expire  = 1'b0;
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (cfg_start) w_state_nxt = S_LOAD;
            S_LOAD:         if (&r_load_done) w_state_nxt = S_START;
            S_START:        w_state_nxt = S_RUN;
            S_RUN:          if (core_done || w_expire) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pipe  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_pipe  <= (r_rd_pipe << 1) | RD_LATENCY'(host_rd_en);
            r_rd_valid <= r_rd_pipe[RD_LATENCY-1];
            if (r_rd_pipe[RD_LATENCY-1]) begin
                r_rd_data <= feat_bram_dout;
            end
        end
    end

    assign bram_we         = r_we;
    assign bram_addr       = r_addr;
    assign bram_din        = r_din;
    assign load_done       = r_load_done;
    assign core_start      = (r_state == S_START);
    assign gat_ready       = (r_state == S_IDLE) || (r_state == S_DONE);
    assign feat_bram_addrb = host_rd_addr[ADDR_W+1:2];
    assign host_rd_data    = r_rd_data;
    assign host_rd_valid   = r_rd_valid;
    assign status          = {{(TOP_WIDTH-16){1'b0}}, r_drop_cnt, 3'b000,
                              w_timeout, r_wr_err, r_state};

    assign w_unused = ^{host_wr_addr[1:0], host_rd_addr[1:0], (TIMEOUT_CYC != 0)};

endmodule
`default_nettype wire

// File: tb/tb_gat_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gat_host_loader
// Purpose  : Self-checking bench: write-vector table, read scoreboard, FSM corners.
// Revision : 1.0
// ============================================================================
module tb_gat_host_loader;

    localparam int NCH = 3;
    localparam int AW  = 18;
    localparam int RDL = 2;

    logic            clk;
    logic            rst;
    logic            cfg_start;
    logic [NCH*AW-1:0] cfg_len;
    logic            host_wr_en;
    logic [1:0]      host_wr_ch;
    logic [AW+1:0]   host_wr_addr;
    logic [31:0]     host_wr_data;
    logic [NCH-1:0]  bram_we;
    logic [AW-1:0]   bram_addr;
    logic [31:0]     bram_din;
    logic [NCH-1:0]  load_done;
    logic            core_start;
    logic            core_done;
    logic            gat_ready;
    logic            host_rd_en;
    logic [AW+1:0]   host_rd_addr;
    logic [AW-1:0]   feat_bram_addrb;
    logic [31:0]     feat_bram_dout;
    logic [31:0]     host_rd_data;
    logic            host_rd_valid;
    logic [31:0]     status;

    gat_host_loader #(
        .NUM_CH(NCH), .TOP_WIDTH(32), .ADDR_W(AW), .RD_LATENCY(RDL), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .host_wr_en(host_wr_en), .host_wr_ch(host_wr_ch), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .load_done(load_done), .core_start(core_start),
        .core_done(core_done), .gat_ready(gat_ready), .host_rd_en(host_rd_en),
        .host_rd_addr(host_rd_addr), .feat_bram_addrb(feat_bram_addrb),
        .feat_bram_dout(feat_bram_dout), .host_rd_data(host_rd_data),
        .host_rd_valid(host_rd_valid), .status(status)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] feat_val(input logic [AW-1:0] a);
        return 32'hFEED_0000 ^ {14'h0, a};
    endfunction

    // Feature BRAM model with RDL cycles of read latency.
    logic [31:0] fpipe [RDL];
    always @(posedge clk) begin
        fpipe[0] <= feat_val(feat_bram_addrb);
        for (int i = 1; i < RDL; i++) fpipe[i] <= fpipe[i-1];
    end
    assign feat_bram_dout = fpipe[RDL-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] d;
        int unsigned c;
    } rd_exp_t;
    rd_exp_t sb [$];
    rd_exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && host_rd_valid) begin
            if (sb.size() == 0) begin
                chk("rd_stray_valid", 32'(host_rd_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rd_data", host_rd_data, mon_e.d);
                chk("rd_cycle", cyc, mon_e.c);
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},      32'(bram_we), 0);
        chk({tag, "_addr"},    32'(bram_addr), 0);
        chk({tag, "_din"},     bram_din, 0);
        chk({tag, "_done"},    32'(load_done), 0);
        chk({tag, "_start"},   32'(core_start), 0);
        chk({tag, "_rdvalid"}, 32'(host_rd_valid), 0);
        chk({tag, "_rddata"},  host_rd_data, 0);
        chk({tag, "_status"},  status, 0);
        chk({tag, "_ready"},   32'(gat_ready), 1);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [AW+1:0] a, input logic [31:0] d);
        host_wr_en = 1'b1; host_wr_ch = ch; host_wr_addr = a; host_wr_data = d;
        tick();
        host_wr_en = 1'b0;
    endtask

    // Session with one word per channel; returns in the first RUN cycle.
    task automatic go_run(input string tag);
        cfg_len = {18'd1, 18'd1, 18'd1};
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wr(2'd0, 20'h0, 32'h1111_0000);
        wr(2'd1, 20'h0, 32'h1111_0001);
        wr(2'd2, 20'h0, 32'h1111_0002);
        chk({tag, "_done"}, 32'(load_done), 3'b111);
        tick();
        chk({tag, "_start"}, 32'(core_start), 1);
        tick();
        chk({tag, "_run"}, 32'(status[2:0]), 3);
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  ch;
        logic [19:0] baddr;
        logic [31:0] data;
        logic [2:0]  we;
        logic [17:0] waddr;
        logic [2:0]  done;
        logic [7:0]  drops;
    } vec_t;
    vec_t vt [12];

    initial begin
        automatic int starts = 0;
        rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; host_wr_en = 1'b0; host_wr_ch = '0;
        host_wr_addr = '0; host_wr_data = '0; core_done = 1'b0; host_rd_en = 1'b0;
        host_rd_addr = '0;

        vt[0]  = '{1'b1, 2'd0, 20'h0, 32'hD000_0000, 3'b001, 18'd0, 3'b000, 8'd0};
        vt[1]  = '{1'b1, 2'd1, 20'h0, 32'hD000_0100, 3'b010, 18'd0, 3'b000, 8'd0};
        vt[2]  = '{1'b1, 2'd2, 20'h0, 32'hD000_0200, 3'b100, 18'd0, 3'b000, 8'd0};
        vt[3]  = '{1'b1, 2'd0, 20'h5, 32'hD000_0001, 3'b001, 18'd1, 3'b000, 8'd0};
        vt[4]  = '{1'b1, 2'd1, 20'h4, 32'hD000_0101, 3'b010, 18'd1, 3'b010, 8'd0};
        vt[5]  = '{1'b1, 2'd1, 20'h8, 32'hDEAD_0001, 3'b000, 18'd0, 3'b010, 8'd1};
        vt[6]  = '{1'b1, 2'd3, 20'h0, 32'hDEAD_0002, 3'b000, 18'd0, 3'b010, 8'd2};
        vt[7]  = '{1'b1, 2'd2, 20'h4, 32'hD000_0201, 3'b100, 18'd1, 3'b010, 8'd2};
        vt[8]  = '{1'b1, 2'd0, 20'h8, 32'hD000_0002, 3'b001, 18'd2, 3'b011, 8'd2};
        vt[9]  = '{1'b1, 2'd2, 20'hB, 32'hD000_0202, 3'b100, 18'd2, 3'b011, 8'd2};
        vt[10] = '{1'b0, 2'd0, 20'h0, 32'h0,         3'b000, 18'd0, 3'b011, 8'd2};
        vt[11] = '{1'b1, 2'd2, 20'hC, 32'hD000_0203, 3'b100, 18'd3, 3'b111, 8'd2};

        tick(); tick();
        chk_reset("rst0");
        rst = 1'b0;
        tick();

        // Session 1: ch0=3, ch1=2, ch2=4 words, with two dropped writes mixed in.
        cfg_len = {18'd4, 18'd2, 18'd3};
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("s1_load", 32'(status[2:0]), 1);
        chk("s1_ready", 32'(gat_ready), 0);
        for (int i = 0; i < 12; i++) begin
            host_wr_en = vt[i].en; host_wr_ch = vt[i].ch;
            host_wr_addr = vt[i].baddr; host_wr_data = vt[i].data;
            tick();
            host_wr_en = 1'b0;
            chk($sformatf("v%0d_we", i), 32'(bram_we), 32'(vt[i].we));
            if (vt[i].we != 3'b000) begin
                chk($sformatf("v%0d_addr", i), 32'(bram_addr), 32'(vt[i].waddr));
                chk($sformatf("v%0d_din", i), bram_din, vt[i].data);
            end
            chk($sformatf("v%0d_done", i), 32'(load_done), 32'(vt[i].done));
            chk($sformatf("v%0d_drops", i), 32'(status[15:8]), 32'(vt[i].drops));
            chk($sformatf("v%0d_state", i), 32'(status[2:0]), 1);
        end
        chk("s1_wr_err", 32'(status[3]), 1);
        tick();
        chk("s1_core_start", 32'(core_start), 1);
        chk("s1_state_start", 32'(status[2:0]), 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (core_start) starts++;
        end
        chk("s1_extra_starts", 32'(starts), 0);
        chk("s1_run", 32'(status[2:0]), 3);
        chk("s1_run_ready", 32'(gat_ready), 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("s1_done_state", 32'(status[2:0]), 4);
        chk("s1_done_ready", 32'(gat_ready), 1);

        // Session 2: zero-length channel 0.
        cfg_len = {18'd1, 18'd1, 18'd0};
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("s2_done_first", 32'(load_done), 3'b001);
        chk("s2_status_clr", 32'(status[15:3]), 0);
        wr(2'd1, 20'h40, 32'hAAAA_0001);
        wr(2'd2, 20'h44, 32'hAAAA_0002);
        chk("s2_done_all", 32'(load_done), 3'b111);
        chk("s2_still_load", 32'(status[2:0]), 1);
        tick();
        chk("s2_core_start", 32'(core_start), 1);
        tick();
        chk("s2_run", 32'(status[2:0]), 3);

        // Pipelined readback, four strobes back to back.
        for (int i = 0; i < 4; i++) begin
            host_rd_en = 1'b1;
            host_rd_addr = 20'(i * 4);
            sb.push_back('{feat_val(18'(i)), cyc + RDL + 1});
            #1;
            chk($sformatf("rd%0d_addrb", i), 32'(feat_bram_addrb), i);
            tick();
        end
        host_rd_en = 1'b0;
        repeat (6) tick();
        chk("rd_pending", sb.size(), 0);
        chk("rd_hold_valid", 32'(host_rd_valid), 0);
        chk("rd_hold_data", host_rd_data, feat_val(18'd3));

        // Reset in RUN with a read in flight.
        host_rd_en = 1'b1;
        host_rd_addr = 20'h10;
        sb.push_back('{feat_val(18'd4), cyc + RDL + 1});
        tick();
        host_rd_en = 1'b0;
        rst = 1'b1;
        sb.delete();
        tick();
        chk_reset("rst1");
        rst = 1'b0;
        repeat (5) tick();
        chk("rst1_no_valid", 32'(host_rd_valid), 0);
        chk("rst1_state", 32'(status[2:0]), 0);

`ifdef GAT_LOADER_TIMEOUT_EN
        go_run("to1");
        repeat (15) tick();
        chk("to1_still_run", 32'(status[2:0]), 3);
        tick();
        chk("to1_done", 32'(status[2:0]), 4);
        chk("to1_flag", 32'(status[4]), 1);
        go_run("to2");
        chk("to2_flag_clr", 32'(status[4]), 0);
        repeat (15) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("to2_done", 32'(status[2:0]), 4);
        chk("to2_flag", 32'(status[4]), 0);
`else
        go_run("nt");
        repeat (40) tick();
        chk("nt_still_run", 32'(status[2:0]), 3);
        chk("nt_flag", 32'(status[4]), 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("nt_done", 32'(status[2:0]), 4);
        chk("nt_ready", 32'(gat_ready), 1);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gat_host_loader.md
Name: gat_host_loader

Overview:
- Parametrised host-side load/readback controller between the 32-bit byte-addressed PS BRAM ports and the GAT core.
- Write side: merges NUM_CH input-BRAM load channels (H data, node info, weights, …) onto one registered word-addressed write bus. Counts words per channel and raises per-channel load_done itself; no software done flags.
- Sequences core start/finish.
- Read side: returns new-feature BRAM contents with an explicit valid after a parametrised read latency.

Parameters:
- NUM_CH, 3, number of input BRAM load channels
- TOP_WIDTH, 32, host data width
- ADDR_W, 18, word-address width for both the internal write bus and the feature read bus
- CH_W, $clog2(NUM_CH) (min 1), channel-select width
- RD_LATENCY, 2, feature BRAM read latency in cycles (≥1)
- TIMEOUT_CYC, 2**24, watchdog limit; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cfg_start  in  1  pulse: begin a new load session
- cfg_len  in  NUM_CH*ADDR_W  expected word count per channel; channel c at [c*ADDR_W +: ADDR_W]
- host_wr_en  in  1  host write strobe
- host_wr_ch  in  CH_W  target channel
- host_wr_addr  in  ADDR_W+2  byte address; bits [1:0] ignored
- host_wr_data  in  TOP_WIDTH  write data
- bram_we  out  NUM_CH  one-hot write enable, registered
- bram_addr  out  ADDR_W  word address (host_wr_addr[ADDR_W+1:2]), registered
- bram_din  out  TOP_WIDTH  write data, registered
- load_done  out  NUM_CH  per-channel loaded flags
- core_start  out  1  one-cycle start pulse to the GAT core
- core_done  in  1  GAT core completion pulse
- gat_ready  out  1  high in IDLE and DONE
- host_rd_en  in  1  feature read strobe
- host_rd_addr  in  ADDR_W+2  byte address
- feat_bram_addrb  out  ADDR_W  = host_rd_addr[ADDR_W+1:2], combinational
- feat_bram_dout  in  TOP_WIDTH  feature BRAM read data
- host_rd_data  out  TOP_WIDTH  returned data
- host_rd_valid  out  1  host_rd_data valid
- status  out  TOP_WIDTH  [2:0] FSM state, [3] wr_err, [4] timeout, [15:8] count of dropped writes (saturating at 255)

Behaviour:
- Reset values: bram_we=0, bram_addr=0, bram_din=0, load_done=0, core_start=0, host_rd_valid=0, host_rd_data=0, status=0, FSM=IDLE (so gat_ready=1).
- FSM states: IDLE=0, LOAD=1, START=2, RUN=3, DONE=4.
  - IDLE/DONE: cfg_start → LOAD; per-channel counters, load_done, wr_err, timeout and drop count are all cleared; cfg_len is latched.
  - LOAD: exits to START in the cycle after load_done becomes all-ones.
  - START: core_start=1 for exactly one cycle, then → RUN.
  - RUN: core_done → DONE.
  - cfg_start is ignored in LOAD, START and RUN.
- Write accept rule: accepted only in LOAD, with host_wr_ch < NUM_CH and load_done[ch]=0.
  - Accepted write: bram_we[ch], bram_addr, bram_din are asserted one cycle later; the channel counter increments.
  - Counter reaching cfg_len[ch]: load_done[ch] is set in the same cycle bram_we pulses for that last word.
- Drop rule: any other host_wr_en is dropped — no bram_we, wr_err set (sticky), drop count increments.
- Zero-length channel: cfg_len[ch]=0 sets load_done[ch] in the first LOAD cycle.
- Counter width: ADDR_W+1, no wrap.
- Readback (any state): host_rd_en at cycle t → host_rd_valid=1 and host_rd_data=feat_bram_dout sampled at t+RD_LATENCY, presented registered at t+RD_LATENCY+1.
  - Back-to-back reads are fully pipelined, one per cycle.
  - host_rd_data holds its value when valid is low.
- rst mid-operation: immediate return to reset values; in-flight reads are lost (no valid).

Optional Feature:
- Macro: GAT_LOADER_TIMEOUT_EN.
- Defined: a RUN-state cycle counter is active. If TIMEOUT_CYC cycles elapse without core_done, the FSM goes RUN→DONE and sets status[4] (sticky until next cfg_start). A core_done arriving in the same cycle as expiry wins: DONE with timeout=0.
- Undefined: no counter; RUN waits indefinitely; status[4] is tied 0.

Test Plan:
- NUM_CH=3, cfg_len={4,2,3}, cfg_start, then interleaved writes with byte addrs 0x0,0x4,… → bram_we one-hot one cycle after each write with bram_addr 0,1,…; load_done=3'b111 after 9 writes; core_start pulses exactly once two cycles later; gat_ready=0 until core_done.
- Extra write to ch1 after its 2 words, plus a write with host_wr_ch=3 → no bram_we, status[3]=1, status[15:8]=2; the FSM sequence is unaffected.
- cfg_len ch0=0, others=1 → load_done[0]=1 in the first LOAD cycle; START follows after the two remaining writes.
- RD_LATENCY=2, host_rd_en in 4 consecutive cycles with addrs 0x0,0x4,0x8,0xC → feat_bram_addrb=0..3; host_rd_valid high for 4 consecutive cycles starting 3 cycles after the first strobe, data in order.
- rst asserted in RUN with a read in flight → all outputs at reset values next edge, no stray host_rd_valid; a new cfg_start works normally.
- With GAT_LOADER_TIMEOUT_EN and TIMEOUT_CYC=16, no core_done → DONE after 16 RUN cycles, status[4]=1; core_done on cycle 16 → status[4]=0.
